dmem_port_arbiter: RTL

//  Shares the single-ported data memory between the CPU load/store path and a debug/loader

---
 rtl/dmem_arb_pkg.sv | 24 ++
 rtl/dmem_port_arbiter_rr_pick2.sv | 61 ++++++
 rtl/dmem_port_arbiter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory port arbiter: FSM state encoding,
// requester IDs and latency limits.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  // Requester IDs double as bit positions in the request/grant vectors.
  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DBG = 1'b1;

  localparam int MAX_MEM_LATENCY = 7;
  localparam int LAT_CNT_W       = 3;

  // True when a memory latency can be tracked by the wait counter.
  function automatic logic latency_ok(input int lat);
    return (lat >= 1) && (lat <= MAX_MEM_LATENCY);
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_rr_pick2.sv
// rr_pick2: two-way request picker used by dmem_port_arbiter.
// Default build is round-robin: on a tie the pointer holder wins and the
// pointer moves to the loser after every grant.
// With DMEM_ARB_FIXED_PRIO_EN defined the CPU (bit 0) always wins and the
// pointer is passed through unchanged.
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       en,
  output logic [1:0] grant,
  output logic       next_ptr
);

  // Winner selection and pointer update for the current request pair.
  always_comb begin
    grant    = 2'b00;
    next_ptr = ptr;
    if (en) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
      if (req[OWNER_CPU]) begin
        grant = 2'b01;
      end else if (req[OWNER_DBG]) begin
        grant = 2'b10;
      end else begin
        grant = 2'b00;
      end
      next_ptr = ptr;
`else
      case (req)
        2'b01: begin
          grant    = 2'b01;
          next_ptr = OWNER_DBG;
        end
        2'b10: begin
          grant    = 2'b10;
          next_ptr = OWNER_CPU;
        end
        2'b11: begin
          if (ptr == OWNER_DBG) begin
            grant    = 2'b10;
            next_ptr = OWNER_CPU;
          end else begin
            grant    = 2'b01;
            next_ptr = OWNER_DBG;
          end
        end
        default: begin
          grant    = 2'b00;
          next_ptr = ptr;
        end
      endcase
`endif
    end else begin
      grant    = 2'b00;
      next_ptr = ptr;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares a single-ported data memory between the CPU
// load/store path and a debug/loader port. One access at a time runs through
// IDLE -> ISSUE -> WAIT -> RESP; the owner gets a one-cycle ack with its data.
// Tie-break policy is chosen by DMEM_ARB_FIXED_PRIO_EN (see rr_pick2);
// undefined gives round-robin.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  if (!latency_ok(MEM_LATENCY)) begin : g_bad_latency
    $error("dmem_port_arbiter: MEM_LATENCY must be in 1..7");
  end

  // Counter value loaded in ISSUE so that WAIT lasts exactly MEM_LATENCY cycles.
  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(MEM_LATENCY - 1);

  arb_state_t           state;
  arb_state_t           next_state;
  logic                 owner;
  logic                 lat_we;
  logic                 rr_ptr;
  logic [LAT_CNT_W-1:0] lat_cnt;
  logic [1:0]           req_vec;
  logic [1:0]           grant;
  logic                 next_ptr;
  logic                 pick_en;
  logic                 pick_we;
  logic [ADDR_W-3:0]    pick_addr;
  logic [DATA_W-1:0]    pick_wdata;
  logic                 unused_addr_bits;

  // Byte-offset bits are ignored: memory is word addressed.
  assign unused_addr_bits = ^{cpu_addr[1:0], dbg_addr[1:0]};

  assign req_vec = {dbg_req, cpu_req};
  assign pick_en = (state == IDLE);

  rr_pick2 u_pick (
    .req      (req_vec),
    .ptr      (rr_ptr),
    .en       (pick_en),
    .grant    (grant),
    .next_ptr (next_ptr)
  );

  // Route the granted requester's fields toward the memory-side registers.
  always_comb begin
    pick_we    = 1'b0;
    pick_addr  = '0;
    pick_wdata = '0;
    if (grant[OWNER_DBG]) begin
      pick_we    = dbg_we;
      pick_addr  = dbg_addr[ADDR_W-1:2];
      pick_wdata = dbg_wdata;
    end else if (grant[OWNER_CPU]) begin
      pick_we    = cpu_we;
      pick_addr  = cpu_addr[ADDR_W-1:2];
      pick_wdata = cpu_wdata;
    end else begin
      pick_we    = 1'b0;
      pick_addr  = '0;
      pick_wdata = '0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state logic; grants are only taken in IDLE, never from RESP.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (grant != 2'b00) begin
          next_state = ISSUE;
        end else begin
          next_state = IDLE;
        end
      end
      ISSUE: begin
        next_state = WAIT;
      end
      WAIT: begin
        if (lat_cnt == '0) begin
          next_state = RESP;
        end else begin
          next_state = WAIT;
        end
      end
      RESP: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Latch owner and access type at grant; advance the tie-break pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner  <= OWNER_CPU;
      lat_we <= 1'b0;
      rr_ptr <= OWNER_CPU;
    end else if ((state == IDLE) && (grant != 2'b00)) begin
      owner  <= grant[OWNER_DBG];
      lat_we <= pick_we;
      rr_ptr <= next_ptr;
    end else begin
      owner  <= owner;
      lat_we <= lat_we;
      rr_ptr <= rr_ptr;
    end
  end

  // Memory strobe and fields: live only during the single ISSUE cycle, 0 elsewhere.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if ((state == IDLE) && (grant != 2'b00)) begin
      mem_en    <= 1'b1;
      mem_we    <= pick_we;
      mem_addr  <= pick_addr;
      mem_wdata <= pick_wdata;
    end else begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end
  end

  // Latency counter: loaded in ISSUE, counts down through WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_cnt <= '0;
    end else if (state == ISSUE) begin
      lat_cnt <= LAT_LOAD;
    end else if ((state == WAIT) && (lat_cnt != '0)) begin
      lat_cnt <= lat_cnt - LAT_CNT_W'(1);
    end else begin
      lat_cnt <= lat_cnt;
    end
  end

  // Capture read data on the last WAIT cycle and pulse the owner's ack in RESP;
  // rdata registers hold their value until the owner's next access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_ack   <= 1'b0;
      dbg_ack   <= 1'b0;
      cpu_rdata <= '0;
      dbg_rdata <= '0;
    end else if ((state == WAIT) && (lat_cnt == '0)) begin
      if (owner == OWNER_DBG) begin
        cpu_ack   <= 1'b0;
        dbg_ack   <= 1'b1;
        dbg_rdata <= lat_we ? '0 : mem_rdata;
      end else begin
        cpu_ack   <= 1'b1;
        dbg_ack   <= 1'b0;
        cpu_rdata <= lat_we ? '0 : mem_rdata;
      end
    end else begin
      cpu_ack <= 1'b0;
      dbg_ack <= 1'b0;
    end
  end

endmodule
